// File: rtl/des_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : des_decrypt_core
// Purpose  : Iterative DES decryption, one Feistel round per clock. Subkeys
//            K16..K1 are produced on the fly by rotating C/D to the right.
// Revision : 1.0 - initial release
// ============================================================================
module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] ciphertext,
    input  logic [63:0] key,
    output logic [63:0] plaintext,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    // Permutation tables hold 1-based DES bit numbers (DES bit 1 = MSB).
    localparam int C_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int C_FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int C_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int C_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int C_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int C_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S-box entries stored row-major: index = row*16 + col.
    localparam int C_SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-C_IP[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-C_FP[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-C_PC1[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-C_PC2[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-C_E[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-C_P[i]];
        return y;
    endfunction

    // Round function: expand, mix key, substitute through S1..S8, permute.
    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s = '0;
        logic [5:0]  b;
        x = e_exp(r) ^ k;
        for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            s[31-4*j -: 4] = 4'(C_SBOX[j][{b[5], b[0], b[4:1]}]);
        end
        return p_perm(s);
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic [1:0]  w_rot;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic [31:0] w_r_next;
    logic        w_unused_parity;

    // Parity bits of the key never reach PC-1.
    assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8],  key[0]};

    // Right-rotate amount for the round about to run (K16 needs none).
    always_comb begin
        w_rot = 2'd2;
        if (r_cnt == 4'd0)
            w_rot = 2'd0;
        else if (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15)
            w_rot = 2'd1;
    end

    // Rotated key halves, current subkey and the new right half.
    always_comb begin
        case (w_rot)
            2'd0:    begin w_c_rot = r_c;                     w_d_rot = r_d;                     end
            2'd1:    begin w_c_rot = {r_c[0],   r_c[27:1]};   w_d_rot = {r_d[0],   r_d[27:1]};   end
            default: begin w_c_rot = {r_c[1:0], r_c[27:2]};   w_d_rot = {r_d[1:0], r_d[27:2]};   end
        endcase
        w_r_next = r_l ^ f_func(r_r, pc2_perm({w_c_rot, w_d_rot}));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and busy decode.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_state_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (r_cnt == 4'd15)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: load on acceptance, one Feistel round per cycle, final output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        {r_l, r_r} <= ip_perm(ciphertext);
                        {r_c, r_d} <= pc1_perm(key);
                        r_cnt      <= 4'd0;
                    end
                end
                ROUND: begin
                    r_l   <= r_r;
                    r_r   <= w_r_next;
                    r_c   <= w_c_rot;
                    r_d   <= w_d_rot;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        // Halves swap before the inverse initial permutation.
                        plaintext <= fp_perm({w_r_next, r_r});
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_decrypt_core
// Purpose  : Self-checking bench for des_decrypt_core with an encrypting
//            reference model for round-trip checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] ciphertext;
    logic [63:0] key;
    logic [63:0] plaintext;
    logic        busy;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2  = 64'h0000000000000000;
    localparam logic [63:0] PT2 = 64'h8787878787878787;

    always #5 clk = ~clk;

    des_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- reference model (forward DES) ----------------
    int ip_t[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int e_t[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sb[8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Selects table-numbered bits (1 = MSB of an in_w-bit value), right-aligned result.
    function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int t[$]);
        logic [63:0] y = '0;
        foreach (t[i]) y = {y[62:0], x[in_w - t[i]]};
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s = '0;
        logic [5:0]  six;
        int          row, col;
        x = 48'(permute({32'h0, r}, 32, e_t)) ^ k;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s   = {s[27:0], 4'(sb[j][row*16 + col])};
        end
        return 32'(permute({32'h0, s}, 32, p_t));
    endfunction

    function automatic logic [63:0] des_encrypt(input logic [63:0] k, input logic [63:0] pt);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk[16];
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = 56'(permute(k, 64, pc1_t));
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            c     = (c << shifts[i]) | (c >> (28 - shifts[i]));
            d     = (d << shifts[i]) | (d >> (28 - shifts[i]));
            sk[i] = 48'(permute({8'h0, c, d}, 56, pc2_t));
        end
        x = permute(pt, 64, ip_t);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, sk[i]);
            l = t;
        end
        return permute({r, l}, 64, fp_t);
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one block for a single cycle; returns 1ns after the accepting edge.
    task automatic start_block(input logic [63:0] k, input logic [63:0] c);
        @(negedge clk);
        key        = k;
        ciphertext = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges to done (bounded); flags busy gaps and busy/done overlap.
    task automatic wait_done(output int lat, output int overlap, output int gap);
        lat = -1; overlap = 0; gap = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (busy && done) overlap = 1;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) gap = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int          lat, ov, gap, dcnt, d1, d2, hold_ok;
        logic [63:0] p1, p2, rk, rp, rc;

        rst_n = 1'b0; start = 1'b0; key = '0; ciphertext = '0;
        repeat (3) @(posedge clk);
        #1;
        chk64("reset_plaintext", plaintext, 64'h0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS vector
        start_block(K1, C1);
        wait_done(lat, ov, gap);
        chk_int("fips_latency", lat, 16);
        chk64("fips_plaintext", plaintext, PT1);
        chk_int("fips_busy_at_done", int'(busy), 0);
        chk_int("fips_busy_overlap", ov, 0);
        chk_int("fips_busy_gap", gap, 0);
        @(posedge clk);
        #1;
        chk_int("fips_done_one_cycle", int'(done), 0);

        // Second vector and parity-flipped key
        start_block(K2, C2);
        wait_done(lat, ov, gap);
        chk_int("vec2_latency", lat, 16);
        chk64("vec2_plaintext", plaintext, PT2);
        start_block(K2 ^ 64'h0101010101010101, C2);
        wait_done(lat, ov, gap);
        chk64("vec2_parity_plaintext", plaintext, PT2);

        // Starts during rounds 3 and 10 are ignored; inputs change mid-block
        start_block(K1, C1);
        dcnt = 0; lat = -1; p1 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = c; p1 = plaintext; end
            end
            if (c == 2 || c == 9) begin
                start = 1'b1; key = K2; ciphertext = C2;
            end else begin
                start = 1'b0;
            end
        end
        chk_int("busy_reject_done_count", dcnt, 1);
        chk_int("busy_reject_latency", lat, 16);
        chk64("busy_reject_plaintext", p1, PT1);

        // Back-to-back with start held high
        @(negedge clk);
        key = K1; ciphertext = C1; start = 1'b1;
        @(posedge clk);
        #1;
        key = K2; ciphertext = C2;
        d1 = -1; d2 = -1; hold_ok = 1; p1 = '0; p2 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) begin d1 = c; p1 = plaintext; end
                else if (d2 < 0) begin d2 = c; p2 = plaintext; end
            end
            if (d1 > 0 && d2 < 0 && !done && plaintext !== PT1) hold_ok = 0;
            if (c == 17) start = 1'b0;
        end
        start = 1'b0;
        chk_int("b2b_first_latency", d1, 16);
        chk64("b2b_first_plaintext", p1, PT1);
        chk_int("b2b_spacing", d2 - d1, 17);
        chk64("b2b_second_plaintext", p2, PT2);
        chk_int("b2b_plaintext_hold", hold_ok, 1);

        // Asynchronous reset at round 8
        start_block(K1, C1);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_done", int'(done), 0);
        chk64("abort_plaintext", plaintext, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_block(K2, C2);
        wait_done(lat, ov, gap);
        chk_int("after_abort_latency", lat, 16);
        chk64("after_abort_plaintext", plaintext, PT2);

        // Random round-trip against the encrypting model
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            rc = des_encrypt(rk, rp);
            start_block(rk, rc);
            wait_done(lat, ov, gap);
            chk_int($sformatf("rt_latency[%0d]", n), lat, 16);
            chk64($sformatf("rt_plaintext[%0d]", n), plaintext, rp);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
